// File: rtl/lock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// lock_pkg / lock_mode_ctrl
//
// Purpose:
//   Top-level mode controller for the electronic lock. Setup mode can only
//   be entered after the master password has been verified. Wrong attempts
//   are counted and lead to a lockout, and an idle prompt times out. The
//   controller routes keypad digit packets and the 6-digit display either to
//   the operational path or to the setup module. It owns the active
//   configuration and commits the setup module's new configuration when the
//   setup module signals a save.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   setup_req           1-cycle request to enter setup mode
//   digitos_value/valid 20-digit BCD packet (unused digits 4'hF) + strobe
//   op_bcd/op_disp_en   display from the operational path
//   set_bcd/set_disp_en display from the setup module
//   data_setup_new/ok   new configuration + save strobe from setup module
//   setup_on            1-cycle start pulse for the setup module
//   set_digitos_valid   digit strobe forwarded to the setup module
//   op_digitos_valid    digit strobe forwarded to the operational path
//   op_enable           operational path enabled (OPER only)
//   bcd_out/disp_en     muxed display
//   cfg_out/cfg_update  active configuration + 1-cycle change pulse
//   locked_out          lockout indication
// ---------------------------------------------------------------------------
package lock_pkg;
    typedef struct packed {
        logic        bip_status;
        logic [7:0]  bip_time;
        logic [7:0]  tranca_aut_time;
        logic [79:0] senha_master;
        logic [79:0] senha_1;
        logic [79:0] senha_2;
        logic [79:0] senha_3;
        logic [79:0] senha_4;
    } setup_pac_t;
endpackage

module lock_mode_ctrl
    import lock_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 500_000_000,
    parameter int FAIL_CYC    = 50_000_000,
    parameter int LOCK_CYC    = 1_500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        setup_req,
    input  logic [79:0] digitos_value,
    input  logic        digitos_valid,
    input  logic [23:0] op_bcd,
    input  logic        op_disp_en,
    input  logic [23:0] set_bcd,
    input  logic        set_disp_en,
    input  setup_pac_t  data_setup_new,
    input  logic        data_setup_ok,
    output logic        setup_on,
    output logic        set_digitos_valid,
    output logic        op_digitos_valid,
    output logic        op_enable,
    output logic [23:0] bcd_out,
    output logic        disp_en,
    output setup_pac_t  cfg_out,
    output logic        cfg_update,
    output logic        locked_out
);

    typedef enum logic [2:0] {
        S_OPER, S_ASK, S_CHECK, S_FAIL, S_LOCK, S_SETUP, S_COMMIT
    } state_t;

    localparam logic [79:0] ALL_E      = {20{4'hE}};
    localparam logic [79:0] ALL_B      = {20{4'hB}};
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] FAIL_LAST  = 32'(FAIL_CYC - 1);
    localparam logic [31:0] LOCK_LAST  = 32'(LOCK_CYC - 1);
    localparam logic [2:0]  TRIES_LIM  = 3'(MAX_TRIES);

    localparam setup_pac_t CFG_RESET = '{
        bip_status:      1'b1,
        bip_time:        8'd5,
        tranca_aut_time: 8'd5,
        senha_master:    {{16{4'hF}}, 16'h1234},
        senha_1:         {20{4'hF}},
        senha_2:         {20{4'hF}},
        senha_3:         {20{4'hF}},
        senha_4:         {20{4'hF}}
    };

    state_t      state;
    logic [2:0]  tries;
    logic [31:0] timer;
    logic [79:0] code;
    setup_pac_t  pend;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_OPER;
            tries      <= '0;
            timer      <= '0;
            setup_on   <= 1'b0;
            cfg_update <= 1'b0;
            cfg_out    <= CFG_RESET;
            code       <= '0;
            pend       <= CFG_RESET;
        end else begin
            setup_on   <= 1'b0;
            cfg_update <= 1'b0;
            case (state)
                S_OPER: begin
                    if (setup_req) begin
                        state <= S_ASK;
                        timer <= '0;
                    end
                end
                S_ASK: begin
                    // Any keypad activity restarts the idle timer, and a
                    // digit in the timeout cycle takes priority over it.
                    if (digitos_valid) begin
                        timer <= '0;
                        if (digitos_value == ALL_B) begin
                            state <= S_OPER;
                        end else if (digitos_value != ALL_E) begin
                            code  <= digitos_value;
                            state <= S_CHECK;
                        end
                    end else if (timer == TMO_LAST) begin
                        timer <= '0;
                        state <= S_OPER;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                S_CHECK: begin
                    timer <= '0;
                    if (code == cfg_out.senha_master) begin
                        tries    <= '0;
                        setup_on <= 1'b1;
                        state    <= S_SETUP;
                    end else begin
                        tries <= tries + 3'd1;
                        state <= (tries + 3'd1 == TRIES_LIM) ? S_LOCK : S_FAIL;
                    end
                end
                S_FAIL: begin
                    if (timer == FAIL_LAST) begin
                        timer <= '0;
                        state <= S_ASK;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                S_LOCK: begin
                    if (timer == LOCK_LAST) begin
                        timer <= '0;
                        tries <= '0;
                        state <= S_OPER;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                S_SETUP: begin
                    // Capture the packet on the save strobe so the commit
                    // does not depend on the setup module holding it.
                    if (data_setup_ok) begin
                        pend  <= data_setup_new;
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    cfg_out    <= pend;
                    cfg_update <= 1'b1;
                    state      <= S_OPER;
                end
                default: state <= S_OPER;
            endcase
        end
    end

    assign op_digitos_valid  = digitos_valid & (state == S_OPER);
    assign set_digitos_valid = digitos_valid & (state == S_SETUP);
    assign op_enable         = (state == S_OPER);
    assign locked_out        = (state == S_LOCK);

    always_comb begin
        bcd_out = op_bcd;
        disp_en = op_disp_en;
        case (state)
            S_ASK, S_CHECK: begin
                bcd_out = 24'h0F_FFFF;
                disp_en = 1'b1;
            end
            S_FAIL, S_LOCK: begin
                bcd_out = 24'hEE_EEEE;
                disp_en = 1'b1;
            end
            S_SETUP, S_COMMIT: begin
                bcd_out = set_bcd;
                disp_en = set_disp_en;
            end
            default: begin
                bcd_out = op_bcd;
                disp_en = op_disp_en;
            end
        endcase
    end

endmodule

// File: tb/tb_lock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lock_mode_ctrl
//
// Purpose:
//   Self-checking bench for lock_mode_ctrl. Each driven cycle pushes the
//   outputs expected during that cycle onto a scoreboard queue; a monitor
//   on the falling edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_lock_mode_ctrl;
    import lock_pkg::*;

    localparam int E_OPER = 0, E_ASK = 1, E_CHECK = 2, E_FAIL = 3,
                   E_LOCK = 4, E_SETUP = 5, E_COMMIT = 6;

    localparam logic [79:0] MASTER = {{16{4'hF}}, 16'h1234};
    localparam logic [79:0] WRONG  = {{16{4'hF}}, 16'h9999};
    localparam logic [79:0] ALL_E  = {20{4'hE}};
    localparam logic [79:0] ALL_B  = {20{4'hB}};

    logic        clk;
    logic        rst;
    logic        setup_req;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic [23:0] op_bcd;
    logic        op_disp_en;
    logic [23:0] set_bcd;
    logic        set_disp_en;
    setup_pac_t  data_setup_new;
    logic        data_setup_ok;
    logic        setup_on;
    logic        set_digitos_valid;
    logic        op_digitos_valid;
    logic        op_enable;
    logic [23:0] bcd_out;
    logic        disp_en;
    setup_pac_t  cfg_out;
    logic        cfg_update;
    logic        locked_out;

    typedef struct {
        int          es;
        bit          so;
        bit          cu;
        bit          dv;
        logic [23:0] obcd;
        logic [23:0] sbcd;
        logic        oden;
        logic        sden;
        setup_pac_t  cfg;
    } exp_t;

    exp_t       sb[$];
    setup_pac_t exp_cfg;
    setup_pac_t cfg_dflt;
    setup_pac_t cfg30;
    setup_pac_t cfg99;
    setup_pac_t cfg_junk;
    int         n_cmp = 0;
    int         n_bad = 0;

    lock_mode_ctrl #(
        .MAX_TRIES  (3),
        .TIMEOUT_CYC(8),
        .FAIL_CYC   (4),
        .LOCK_CYC   (10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .setup_req        (setup_req),
        .digitos_value    (digitos_value),
        .digitos_valid    (digitos_valid),
        .op_bcd           (op_bcd),
        .op_disp_en       (op_disp_en),
        .set_bcd          (set_bcd),
        .set_disp_en      (set_disp_en),
        .data_setup_new   (data_setup_new),
        .data_setup_ok    (data_setup_ok),
        .setup_on         (setup_on),
        .set_digitos_valid(set_digitos_valid),
        .op_digitos_valid (op_digitos_valid),
        .op_enable        (op_enable),
        .bcd_out          (bcd_out),
        .disp_en          (disp_en),
        .cfg_out          (cfg_out),
        .cfg_update       (cfg_update),
        .locked_out       (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: compares the cycle's expectation half a clock after it was driven.
    always @(negedge clk) begin
        exp_t        e;
        logic [23:0] eb;
        logic        ed;
        bit          chk_disp;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_disp = 1'b1;
            eb = e.obcd;
            ed = e.oden;
            case (e.es)
                E_OPER:         begin eb = e.obcd;      ed = e.oden; end
                E_ASK:          begin eb = 24'h0FFFFF;  ed = 1'b1;   end
                E_FAIL, E_LOCK: begin eb = 24'hEEEEEE;  ed = 1'b1;   end
                E_SETUP:        begin eb = e.sbcd;      ed = e.sden; end
                default:        chk_disp = 1'b0;
            endcase
            check("op_enable",  512'(op_enable),  512'(e.es == E_OPER));
            check("locked_out", 512'(locked_out), 512'(e.es == E_LOCK));
            check("setup_on",   512'(setup_on),   512'(e.so));
            check("cfg_update", 512'(cfg_update), 512'(e.cu));
            check("op_dv",      512'(op_digitos_valid),  512'(e.dv && e.es == E_OPER));
            check("set_dv",     512'(set_digitos_valid), 512'(e.dv && e.es == E_SETUP));
            check("cfg_out",    512'(cfg_out),    512'(e.cfg));
            if (chk_disp) begin
                check("bcd_out", 512'(bcd_out), 512'(eb));
                check("disp_en", 512'(disp_en), 512'(ed));
            end
        end
    end

    task automatic step(input int es, input bit so, input bit cu, input bit dv,
                        input logic [79:0] val, input bit req, input bit ok, input bit rs);
        exp_t e;
        rst           = rs;
        setup_req     = req;
        digitos_valid = dv;
        digitos_value = val;
        data_setup_ok = ok;
        op_bcd        = 24'($urandom);
        set_bcd       = 24'($urandom);
        op_disp_en    = 1'($urandom);
        set_disp_en   = 1'($urandom);
        e.es   = es;
        e.so   = so;
        e.cu   = cu;
        e.dv   = dv;
        e.obcd = op_bcd;
        e.sbcd = set_bcd;
        e.oden = op_disp_en;
        e.sden = set_disp_en;
        e.cfg  = exp_cfg;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int es, input int n);
        for (int i = 0; i < n; i++) step(es, 0, 0, 0, '1, 0, 0, 0);
    endtask

    // One wrong code from ASK; ends either in a full FAIL or a full LOCKOUT period.
    task automatic wrong_round(input bit to_lock);
        step(E_ASK, 0, 0, 1, WRONG, 0, 0, 0);
        step(E_CHECK, 0, 0, 0, '1, 0, 0, 0);
        if (to_lock) begin
            for (int i = 0; i < 10; i++)
                step(E_LOCK, 0, 0, (i == 5), MASTER, (i % 3 == 0), 0, 0);
        end else begin
            step(E_FAIL, 0, 0, 1, MASTER, 1, 0, 0);
            idle(E_FAIL, 3);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cfg_dflt.bip_status      = 1'b1;
        cfg_dflt.bip_time        = 8'd5;
        cfg_dflt.tranca_aut_time = 8'd5;
        cfg_dflt.senha_master    = MASTER;
        cfg_dflt.senha_1         = {20{4'hF}};
        cfg_dflt.senha_2         = {20{4'hF}};
        cfg_dflt.senha_3         = {20{4'hF}};
        cfg_dflt.senha_4         = {20{4'hF}};
        cfg30 = cfg_dflt;
        cfg30.bip_time = 8'd30;
        cfg99 = cfg_dflt;
        cfg99.bip_time = 8'd99;
        cfg99.senha_1  = {{16{4'hF}}, 16'h4321};
        cfg_junk = cfg_dflt;
        cfg_junk.bip_time     = 8'd77;
        cfg_junk.senha_master = '0;

        exp_cfg        = cfg_dflt;
        rst            = 1'b1;
        setup_req      = 1'b0;
        digitos_valid  = 1'b0;
        digitos_value  = '1;
        data_setup_ok  = 1'b0;
        data_setup_new = cfg_dflt;
        op_bcd         = '0;
        set_bcd        = '0;
        op_disp_en     = 1'b0;
        set_disp_en    = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(E_OPER, 0, 0, 0, '1, 0, 0, 1);
        step(E_OPER, 0, 0, 0, '1, 0, 0, 1);
        idle(E_OPER, 1);

        // Correct master password, setup run and commit
        step(E_OPER, 0, 0, 1, MASTER, 1, 0, 0);
        idle(E_ASK, 2);
        step(E_ASK, 0, 0, 1, MASTER, 0, 0, 0);
        step(E_CHECK, 0, 0, 1, WRONG, 0, 0, 0);
        step(E_SETUP, 1, 0, 1, WRONG, 1, 0, 0);
        idle(E_SETUP, 1);
        data_setup_new = cfg30;
        step(E_SETUP, 0, 0, 0, '1, 0, 1, 0);
        data_setup_new = cfg_junk;
        step(E_COMMIT, 0, 0, 0, '1, 0, 0, 0);
        exp_cfg = cfg30;
        step(E_OPER, 0, 1, 0, '1, 0, 0, 0);
        idle(E_OPER, 1);

        // Wrong code, cancel keeps the try count, then lockout on the third
        step(E_OPER, 0, 0, 0, '1, 1, 0, 0);
        wrong_round(0);
        step(E_ASK, 0, 0, 1, ALL_B, 0, 0, 0);
        idle(E_OPER, 1);
        step(E_OPER, 0, 0, 0, '1, 1, 0, 0);
        wrong_round(0);
        wrong_round(1);
        idle(E_OPER, 1);

        // After lockout the count restarts: two FAILs before the next LOCKOUT
        step(E_OPER, 0, 0, 0, '1, 1, 0, 0);
        wrong_round(0);
        wrong_round(0);
        wrong_round(1);
        idle(E_OPER, 1);

        // Timeout with no digits
        step(E_OPER, 0, 0, 0, '1, 1, 0, 0);
        idle(E_ASK, 8);
        idle(E_OPER, 1);

        // All-E is ignored but restarts the idle timer
        step(E_OPER, 0, 0, 0, '1, 1, 0, 0);
        idle(E_ASK, 3);
        step(E_ASK, 0, 0, 1, ALL_E, 0, 0, 0);
        idle(E_ASK, 8);
        idle(E_OPER, 1);

        // A digit in the timeout cycle wins
        step(E_OPER, 0, 0, 0, '1, 1, 0, 0);
        idle(E_ASK, 7);
        step(E_ASK, 0, 0, 1, MASTER, 0, 0, 0);
        step(E_CHECK, 0, 0, 0, '1, 0, 0, 0);
        step(E_SETUP, 1, 0, 0, '1, 0, 0, 0);

        // Reset during the commit cycle discards the pending configuration
        data_setup_new = cfg99;
        step(E_SETUP, 0, 0, 0, '1, 0, 1, 0);
        exp_cfg = cfg_dflt;
        step(E_OPER, 0, 0, 0, '1, 0, 0, 1);
        idle(E_OPER, 3);

        while (sb.size() > 0) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
